camera_fifo_writer: RTL and testbench

Write-side producer for the camera FIFO. It takes a pixel stream from the camera capture logic and packs PACK pixels into one FIFO word. It drives the FIFO's wr_data/wr_en and watches wr_vld (not full) for backpressure. On overflow it drops the rest of the frame and records the loss, so the read side never sees a torn frame mid-stream.

---
 rtl/camera_fifo_writer.sv | 139 +++++++++++++
 tb/tb_camera_fifo_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/camera_fifo_writer.sv
// camera_fifo_writer: packs PACK camera pixels per FIFO word and writes the
// words to the FIFO. If the FIFO rejects a write, the rest of the frame is
// dropped and the loss is recorded, so the read side never sees a torn frame.
module camera_fifo_writer #(
  parameter int              PIX_W   = 16,
  parameter int              PACK    = 2,
  parameter int              WORD_W  = PIX_W * PACK,
  parameter int              CNT_W   = 16,
  parameter logic [PIX_W-1:0] PAD_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              line_end,
  output logic [WORD_W-1:0] fifo_wr_data,
  output logic              fifo_wr_en,
  input  logic              fifo_wr_vld,
  input  logic              ovf_clr,
  output logic              ovf_flag,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frame_words,
  output logic [1:0]        state_o
);

  // Slot index is 3 bits wide so that PACK=1 still has a legal counter.
  localparam int                SLOT_W   = 3;
  localparam logic [WORD_W-1:0] PAD_WORD = {PACK{PAD_VAL}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SLOT_W-1:0]   r_slot;
  logic [WORD_W-1:0]   r_buf;
  logic                r_wr_vld_p1;
  logic [WORD_W-1:0]   r_wr_data_p1;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_frame_words;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic                r_ovf;

  logic [SLOT_W-1:0]   w_slot;
  logic [WORD_W-1:0]   w_word;
  logic                w_last;
  logic                w_ovf;
  logic                w_wr_ok;
  logic                w_take;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_ovf   = r_wr_vld_p1 & ~fifo_wr_vld;
  assign w_wr_ok = r_wr_vld_p1 & fifo_wr_vld;
  // A frame_start pixel always opens the new frame, even from IDLE/DROP or
  // while the previous word is being rejected.
  assign w_take  = pix_vld & (frame_start | ((r_state == S_ACTIVE) & ~w_ovf));

  // Build the word including the current pixel; frame_start discards any partial word.
  always_comb begin
    w_slot = frame_start ? '0 : r_slot;
    w_word = frame_start ? PAD_WORD : r_buf;
    for (int k = 0; k < PACK; k++) begin
      if (w_slot == SLOT_W'(k)) w_word[k*PIX_W +: PIX_W] = pix_data;
    end
    w_last = (w_slot == SLOT_W'(PACK - 1)) | line_end;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: frame_start beats a same-cycle overflow.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start)  w_state_nxt = S_ACTIVE;
    else if (w_ovf)   w_state_nxt = S_DROP;
  end

  // Pack stage p0 -> write stage p1: slot tracking and the registered FIFO write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_vld_p1  <= 1'b0;
      r_wr_data_p1 <= '0;
      r_slot       <= '0;
      r_buf        <= PAD_WORD;
    end else begin
      r_wr_vld_p1 <= w_take & w_last;
      if (w_take & w_last) r_wr_data_p1 <= w_word;
      if (w_take) begin
        r_slot <= w_last ? '0 : w_slot + SLOT_W'(1);
        r_buf  <= w_last ? PAD_WORD : w_word;
      end else if (frame_start) begin
        r_slot <= '0;
        r_buf  <= PAD_WORD;
      end
    end
  end

  // Frame word accounting, drop counting and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_cnt    <= '0;
      r_frame_words <= '0;
      r_drop_cnt    <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (frame_start) begin
        r_frame_words <= w_wr_ok ? sat_inc(r_word_cnt) : r_word_cnt;
        r_word_cnt    <= '0;
      end else if (w_wr_ok) begin
        r_word_cnt <= sat_inc(r_word_cnt);
      end
      if (w_ovf) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_ovf      <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign fifo_wr_en   = r_wr_vld_p1;
  assign fifo_wr_data = r_wr_data_p1;
  assign ovf_flag     = r_ovf;
  assign drop_cnt     = r_drop_cnt;
  assign frame_words  = r_frame_words;
  assign state_o      = r_state;

endmodule

// File: tb/tb_camera_fifo_writer.sv
// Bench for camera_fifo_writer: a per-cycle vector table with expected
// outputs, a queue of expected FIFO words, and hand-written sequences for
// mid-frame reset and drop counter saturation (on a narrow-counter copy).
module tb_camera_fifo_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, frame_start, pix_vld, line_end, fifo_wr_vld, ovf_clr;
  logic [15:0] pix_data;

  logic [31:0] wr_data;
  logic        wr_en, ovf;
  logic [15:0] drop, fw;
  logic [1:0]  st;

  logic [15:0] s_wr_data;
  logic        s_wr_en, s_ovf;
  logic [3:0]  s_drop, s_fw;
  logic [1:0]  s_st;

  camera_fifo_writer #(.PIX_W(16), .PACK(2), .CNT_W(16), .PAD_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_vld(pix_vld),
    .pix_data(pix_data), .line_end(line_end), .fifo_wr_data(wr_data),
    .fifo_wr_en(wr_en), .fifo_wr_vld(fifo_wr_vld), .ovf_clr(ovf_clr),
    .ovf_flag(ovf), .drop_cnt(drop), .frame_words(fw), .state_o(st));

  camera_fifo_writer #(.PIX_W(16), .PACK(1), .CNT_W(4), .PAD_VAL(16'h0000)) u_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_vld(pix_vld),
    .pix_data(pix_data), .line_end(line_end), .fifo_wr_data(s_wr_data),
    .fifo_wr_en(s_wr_en), .fifo_wr_vld(fifo_wr_vld), .ovf_clr(ovf_clr),
    .ovf_flag(s_ovf), .drop_cnt(s_drop), .frame_words(s_fw), .state_o(s_st));

  typedef struct {
    logic        fs, pv;
    logic [15:0] pd;
    logic        le, wv, clr;
    logic        push;
    logic [31:0] word;
    logic        en, ovf;
    logic [15:0] drop, fw;
    logic [1:0]  st;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t V(input logic fs, input logic pv, input logic [15:0] pd,
                             input logic le, input logic wv, input logic clr,
                             input logic push, input logic [31:0] word,
                             input logic en, input logic o, input logic [15:0] d,
                             input logic [15:0] f, input logic [1:0] s);
    vec_t v;
    v.fs = fs; v.pv = pv; v.pd = pd; v.le = le; v.wv = wv; v.clr = clr;
    v.push = push; v.word = word; v.en = en; v.ovf = o; v.drop = d; v.fw = f; v.st = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Pop the expected word whenever the DUT writes.
  task automatic sb_check(input string nm);
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s.sb: got write %h required no write", nm, wr_data);
      end else begin
        chk({nm, ".data"}, wr_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic fs, input logic pv, input logic [15:0] pd,
                       input logic le, input logic wv, input logic clr);
    frame_start = fs; pix_vld = pv; pix_data = pd; line_end = le;
    fifo_wr_vld = wv; ovf_clr = clr;
  endtask

  task automatic run_row(input int i, input vec_t v);
    string nm;
    nm = $sformatf("row%0d", i);
    @(negedge clk);
    drive(v.fs, v.pv, v.pd, v.le, v.wv, v.clr);
    if (v.push) exp_q.push_back(v.word);
    @(posedge clk);
    #1;
    chk({nm, ".wr_en"}, 32'(wr_en), 32'(v.en));
    chk({nm, ".ovf"},   32'(ovf),   32'(v.ovf));
    chk({nm, ".drop"},  32'(drop),  32'(v.drop));
    chk({nm, ".fw"},    32'(fw),    32'(v.fw));
    chk({nm, ".state"}, 32'(st),    32'(v.st));
    sb_check(nm);
  endtask

  initial begin
    //           fs pv pd        le wv clr push word          en ovf drop fw st
    vecs.push_back(V(0, 1, 16'h1234, 0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0)); // pixels while IDLE
    vecs.push_back(V(0, 1, 16'h5678, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(V(1, 1, 16'h1111, 0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 1)); // basic pack
    vecs.push_back(V(0, 1, 16'h2222, 0, 1, 0, 1, 32'h22221111, 1, 0, 0, 0, 1));
    vecs.push_back(V(0, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 1));
    vecs.push_back(V(1, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h000A, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1)); // line-end pad
    vecs.push_back(V(0, 1, 16'h000B, 0, 1, 0, 1, 32'h000B000A, 1, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h000C, 1, 1, 0, 1, 32'h0000000C, 1, 0, 0, 1, 1));
    vecs.push_back(V(0, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h0005, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1)); // partial discarded
    vecs.push_back(V(1, 1, 16'h0006, 0, 1, 0, 0, 32'h0,        0, 0, 0, 2, 1));
    vecs.push_back(V(0, 1, 16'h0007, 0, 1, 0, 1, 32'h00070006, 1, 0, 0, 2, 1));
    vecs.push_back(V(0, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 0, 2, 1));
    vecs.push_back(V(1, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1)); // overflow frame
    vecs.push_back(V(0, 1, 16'h0021, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h0022, 0, 1, 0, 1, 32'h00220021, 1, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h0023, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h0024, 0, 1, 0, 1, 32'h00240023, 1, 0, 0, 1, 1));
    vecs.push_back(V(0, 1, 16'h0025, 0, 0, 0, 0, 32'h0,        0, 1, 1, 1, 2));
    vecs.push_back(V(0, 1, 16'h0026, 0, 1, 0, 0, 32'h0,        0, 1, 1, 1, 2));
    vecs.push_back(V(0, 1, 16'h0027, 1, 1, 0, 0, 32'h0,        0, 1, 1, 1, 2));
    vecs.push_back(V(1, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 1, 1, 1, 1));
    vecs.push_back(V(0, 1, 16'h0031, 1, 1, 0, 1, 32'h00000031, 1, 1, 1, 1, 1)); // clr vs ovf
    vecs.push_back(V(0, 0, 16'h0,    0, 0, 1, 0, 32'h0,        0, 1, 2, 1, 2));
    vecs.push_back(V(0, 0, 16'h0,    0, 1, 1, 0, 32'h0,        0, 0, 2, 1, 2));
    vecs.push_back(V(1, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 2, 0, 1));
    vecs.push_back(V(0, 1, 16'h0041, 1, 1, 0, 1, 32'h00000041, 1, 0, 2, 0, 1)); // write + frame_start
    vecs.push_back(V(1, 0, 16'h0,    0, 1, 0, 0, 32'h0,        0, 0, 2, 1, 1));
    vecs.push_back(V(0, 1, 16'h0061, 1, 1, 0, 1, 32'h00000061, 1, 0, 2, 1, 1)); // ovf + frame_start
    vecs.push_back(V(1, 0, 16'h0,    0, 0, 0, 0, 32'h0,        0, 1, 3, 0, 1));
    vecs.push_back(V(0, 1, 16'h0071, 1, 1, 0, 1, 32'h00000071, 1, 1, 3, 0, 1)); // wr_en high for reset

    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wr_en", 32'(wr_en), 32'h0);
    chk("rst.data",  wr_data,    32'h0);
    chk("rst.ovf",   32'(ovf),   32'h0);
    chk("rst.drop",  32'(drop),  32'h0);
    chk("rst.fw",    32'(fw),    32'h0);
    chk("rst.state", 32'(st),    32'h0);
    chk("rst.sat_drop", 32'(s_drop), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);

    // Reset while a write is being presented and would be rejected: reset wins.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1, 16'h0081, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("midrst.wr_en", 32'(wr_en), 32'h0);
    chk("midrst.data",  wr_data,    32'h0);
    chk("midrst.ovf",   32'(ovf),   32'h0);
    chk("midrst.drop",  32'(drop),  32'h0);
    chk("midrst.fw",    32'(fw),    32'h0);
    chk("midrst.state", 32'(st),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back rejected single-pixel words on the 4-bit-counter copy.
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      drive(1, 1, 16'(j), 0, 0, 0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.drop", j), 32'(s_drop), (j - 1 > 15) ? 32'd15 : 32'(j - 1));
    end
    chk("sat.ovf",   32'(s_ovf), 32'h1);
    chk("sat.state", 32'(s_st),  32'h1);

    @(negedge clk);
    drive(0, 0, 16'h0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("sb.leftover", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
